// File: rtl/invert_word_ctrl.sv
// Purpose    : word-level sequencer around one bit-serial two's-complement converter (invert).
// Latency    : neg=1 -> WIDTH+2+CONV_LAT edges from accept to out_valid; neg=0 -> 1 edge.
// Backpressure: single-word buffer; in_ready only in IDLE, result held in DONE until out_ready.
//
// Ports:
//   t_clk, r               clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready      request handshake; in_data/in_neg captured on the handshake
//   ser_i, ser_r, ser_y    serial link to the converter (data in, converter reset, data out)
//   out_valid/out_ready    result handshake; out_data/out_ovf stable while out_valid=1
//   busy                   high whenever a word is in flight (state != IDLE)
module invert_word_ctrl #(
    parameter int WIDTH    = 8,
    parameter int CONV_LAT = 0
) (
    input  logic             t_clk,
    input  logic             r,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_neg,
    output logic             ser_i,
    output logic             ser_r,
    input  logic             ser_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             busy
);

    localparam int               CNT_MAX  = WIDTH + CONV_LAT - 1;
    localparam int               CW       = $clog2(WIDTH + CONV_LAT + 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(CNT_MAX);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLR   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] in_sreg_q, in_sreg_d;
    logic [WIDTH-1:0] out_sreg_q, out_sreg_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;
    logic             out_ovf_q, out_ovf_d;

    logic [WIDTH-1:0] out_sreg_nxt;
    logic             cap_en;

    // With a registered converter the first CONV_LAT cycles of SHIFT carry
    // stale converter output, so capture only starts once the pipe is primed.
    generate
        if (CONV_LAT == 0) begin : g_cap_mealy
            assign cap_en = 1'b1;
        end else begin : g_cap_reg
            assign cap_en = (cnt_q >= CW'(CONV_LAT));
        end
    endgenerate

    // Converter output enters at the MSB; after WIDTH captures the first
    // converted bit has walked down to the LSB.
    assign out_sreg_nxt = {ser_y, out_sreg_q[WIDTH-1:1]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        in_sreg_d  = in_sreg_q;
        out_sreg_d = out_sreg_q;
        out_data_d = out_data_q;
        neg_d      = neg_q;
        ovf_d      = ovf_q;
        out_ovf_d  = out_ovf_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    in_sreg_d = in_data;
                    neg_d     = in_neg;
                    // Negating the most-negative value wraps back onto itself.
                    ovf_d     = in_neg && (in_data == MOST_NEG);
                    if (in_neg) begin
                        state_d = CLR;
                    end else begin
                        out_data_d = in_data;
                        out_ovf_d  = 1'b0;
                        state_d    = DONE;
                    end
                end
            end
            CLR: begin
                cnt_d      = '0;
                out_sreg_d = '0;
                state_d    = SHIFT;
            end
            SHIFT: begin
                in_sreg_d = {1'b0, in_sreg_q[WIDTH-1:1]};
                cnt_d     = cnt_q + 1'b1;
                if (cap_en) begin
                    out_sreg_d = out_sreg_nxt;
                end
                if (cnt_q == CNT_LAST) begin
                    out_data_d = out_sreg_nxt;
                    out_ovf_d  = ovf_q && neg_q;
                    cnt_d      = '0;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge t_clk or posedge r) begin
        if (r) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            in_sreg_q  <= '0;
            out_sreg_q <= '0;
            out_data_q <= '0;
            neg_q      <= 1'b0;
            ovf_q      <= 1'b0;
            out_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            in_sreg_q  <= in_sreg_d;
            out_sreg_q <= out_sreg_d;
            out_data_q <= out_data_d;
            neg_q      <= neg_d;
            ovf_q      <= ovf_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    // The converter is also held in reset while the block itself is.
    assign ser_r     = r || (state_q == CLR);
    // in_sreg is zero-filled, so ser_i falls to 0 after the last data bit.
    assign ser_i     = (state_q == SHIFT) && in_sreg_q[0];
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

endmodule
